tachgen16: RTL and testbench
============================

# tachgen16

Quadrature tach signal generator, the transmit-side counterpart of the tach counter. From a 16-bit step count, a direction and a step period, it emits a clean 2-bit gray-code sequence on `tach[1:0]`. Each emitted transition is exactly one up or down count as seen by the tach counter. It is used for encoder emulation, loopback self-test of the tach path, and bench stimulus. It sits beside the tach counter and is loaded over the same byte-wide high/low register style.

## Interface
- `PERIOD_W`, default 8: width of the step-period input.
- `PHASE_INIT`, default 2'b00: `tach` value after reset.

- `clk`  in  1  system clock; all logic on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle request to begin a run; honoured only in IDLE.
- `abort`  in  1  terminates a run immediately.
- `freeze`  in  1  while high, pauses a run: divider and phase hold.
- `dir`  in  1  direction, sampled with `start`: 1 = up (counter increments), 0 = down.
- `stepsh`  in  8  high byte of the step count, sampled with `start`.
- `stepsl`  in  8  low byte of the step count, sampled with `start`.
- `period`  in  PERIOD_W  clocks between transitions minus one, sampled with `start`.
- `tach`  out  2  quadrature output.
- `busy`  out  1  high in RUN.
- `done`  out  1  one-cycle pulse when a run completes normally.
- `remh`  out  8  high byte of the remaining step count.
- `reml`  out  8  low byte of the remaining step count.

## Operation
- Phase sequence, up direction: 00→01→11→10→00. Down direction is the exact reverse. Every transition changes exactly one bit, and no other transition is ever produced.
- Two states:
  - IDLE: `busy`=0.
  - RUN: `busy`=1.
- IDLE behaviour on `start`=1 and `abort`=0:
  - If steps = {stepsh,stepsl} = 0: stay in IDLE and pulse `done` next cycle.
  - Otherwise: latch dir, steps and period, load the divider with period, and enter RUN.
- RUN, per clock, in priority order:
  - `abort`: go to IDLE. No `done`. The remaining count holds its current value. `tach` holds.
  - `freeze`: hold everything.
  - divider ≠ 0: decrement the divider.
  - divider = 0: advance phase one step in the latched direction, decrement remaining, reload the divider with period. If remaining was 1, go to IDLE and pulse `done` in the same cycle.
- `start` in RUN is ignored. `start` and `abort` together in IDLE: abort wins and nothing starts.
- Phase is never reset between runs. A new run continues from the current `tach` value, so the receiver never sees an illegal jump.
- Remaining-count arithmetic is unsigned 16-bit. 0xFFFF is legal, and the count never wraps because the run ends at 0.
- Reset values: `tach`=PHASE_INIT, `busy`=0, `done`=0, `remh`=`reml`=0, state IDLE, divider 0.
- Reset asserted mid-run: immediately enter the reset state above. No `done`.

## Timing
- All outputs are registered.
- `start` is sampled at edge N. `busy` rises after edge N. The first `tach` change appears after edge N+period+1.
- Successive transitions are exactly period+1 clocks apart. period=0 gives one transition per clock.
- Each freeze-high cycle during RUN stretches the current interval by exactly one clock.
- The final transition, `busy` falling and the `done` pulse all appear after the same edge. A new `start` is accepted on the following cycle.
- `remh`/`reml` update in the same cycle as the corresponding `tach` transition.

## Configuration
- `TACHGEN_INVPHASE_EN` defined:
  - Adds input port `invphase` (1 bit).
  - When high, `tach[0]` and `tach[1]` are swapped at the output, matching the tach counter's phase inversion.
  - It is a purely combinational swap after the phase register, so it does not affect the internal state.
- Undefined: no port; `tach` comes straight from the phase register.

## Structure
- Shared package contents:
  - state enum (IDLE, RUN)
  - the 4-entry up-sequence constants
  - `next_phase(phase, dir)` function
  - steps width constant (16)
- One sub-module, `tachgen_divider`: the loadable down-counter. Inputs: load, value, hold. Output: zero flag.
- The FSM, phase register and remaining counter live in the top module.

## Test plan
- Reset with PHASE_INIT=00, then start dir=1, steps=4, period=2 → `tach` is 01, 11, 10, 00. Transitions come 3 clocks apart, the first 3 clocks after start. `done` pulses with the 4th transition; `busy` is high for 12 cycles.
- From `tach`=00, start dir=0, steps=5, period=0 → `tach` is 10, 11, 01, 00, 10 on consecutive clocks. `remh`:`reml` counts 4..0.
- Loop `tach` into the tach counter with filter CE held high. Run up 1000 then down 300, period=7 → counter reads 0x02BC. The generator also reports remaining 0x0000.
- Start with steps=0 → `done` pulses next cycle, `busy` never rises, `tach` unchanged.
- Run steps=10, period=1: freeze for 3 cycles after the 2nd transition, then assert abort after the 5th → the interval is stretched by 3 clocks. Abort returns to IDLE with no `done` and remaining=5. A `start` issued while busy is ignored.
- Assert `rst_n` low mid-run → `busy`=0, `tach`=PHASE_INIT and `remh`/`reml`=0 immediately, with no `done`. With `TACHGEN_INVPHASE_EN` and `invphase`=1, an up run decodes as down counts.

Source files
------------

// File: rtl/tachgen16_pkg.sv
// tachgen16_pkg: shared FSM state, quadrature sequence and phase stepping helper for tachgen16.
package tachgen16_pkg;
    typedef enum logic {IDLE, RUN} state_t;
    localparam int STEPS_W = 16;
    localparam logic [1:0] UP_SEQ [4] = '{2'b00, 2'b01, 2'b11, 2'b10};
    // Gray phase maps to its sequence index as {p1, p1^p0}; step one index in the chosen direction.
    function automatic logic [1:0] next_phase(input logic [1:0] phase, input logic dir);
        logic [1:0] idx;
        idx = {phase[1], ^phase};
        return dir ? UP_SEQ[idx + 2'd1] : UP_SEQ[idx - 2'd1];
    endfunction
endpackage

// File: rtl/tachgen16_if.sv
// tachgen16_if: control/status bundle of the quadrature tach generator.
// Carries invphase only when TACHGEN_INVPHASE_EN is defined.
interface tachgen16_if #(parameter int PERIOD_W = 8);
    logic                start;
    logic                abort;
    logic                freeze;
    logic                dir;
    logic [7:0]          stepsh;
    logic [7:0]          stepsl;
    logic [PERIOD_W-1:0] period;
    logic [1:0]          tach;
    logic                busy;
    logic                done;
    logic [7:0]          remh;
    logic [7:0]          reml;
`ifdef TACHGEN_INVPHASE_EN
    logic                invphase;
    modport master (output start, abort, freeze, dir, stepsh, stepsl, period, invphase,
                    input tach, busy, done, remh, reml);
    modport slave  (input start, abort, freeze, dir, stepsh, stepsl, period, invphase,
                    output tach, busy, done, remh, reml);
`else
    modport master (output start, abort, freeze, dir, stepsh, stepsl, period,
                    input tach, busy, done, remh, reml);
    modport slave  (input start, abort, freeze, dir, stepsh, stepsl, period,
                    output tach, busy, done, remh, reml);
`endif
endinterface

// File: rtl/tachgen16_divider.sv
// tachgen_divider: loadable down-counter pacing tach transitions; load beats hold.
module tachgen_divider #(parameter int W = 8) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic [W-1:0] i_value,
    input  logic         i_hold,
    output logic         o_zero
);
    logic [W-1:0] r_cnt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_cnt <= '0;
        else if (i_load) r_cnt <= i_value;
        else if (!i_hold && r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end
    assign o_zero = r_cnt == '0;
endmodule

// File: rtl/tachgen16.sv
// tachgen16: quadrature tach generator emitting a counted gray-code run at a programmable step period.
// Optional TACHGEN_INVPHASE_EN adds an output phase swap driven by invphase.
module tachgen16
    import tachgen16_pkg::*;
#(
    parameter int         PERIOD_W   = 8,
    parameter logic [1:0] PHASE_INIT = 2'b00
) (
    input  logic   clk,
    input  logic   rst_n,
    tachgen16_if.slave bus
);
    state_t               r_state, w_next;
    logic [1:0]           r_phase;
    logic [STEPS_W-1:0]   r_rem;
    logic [PERIOD_W-1:0]  r_period;
    logic                 r_dir, r_done;
    logic [STEPS_W-1:0]   w_steps;
    logic [PERIOD_W-1:0]  w_value;
    logic                 w_start, w_step, w_zero_start, w_zero, w_last, w_hold;

    assign w_steps = {bus.stepsh, bus.stepsl};
    assign w_last  = r_rem == STEPS_W'(1);
    assign w_value = (r_state == IDLE) ? bus.period : r_period;
    assign w_hold  = (r_state == IDLE) || bus.freeze || bus.abort;

    tachgen_divider #(.W(PERIOD_W)) u_div (
        .clk(clk), .rst_n(rst_n), .i_load(w_start || w_step),
        .i_value(w_value), .i_hold(w_hold), .o_zero(w_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        w_start      = 1'b0;
        w_step       = 1'b0;
        w_zero_start = 1'b0;
        if (r_state == IDLE) begin
            if (bus.start && !bus.abort) begin
                w_zero_start = w_steps == '0;
                w_start      = w_steps != '0;
                w_next       = (w_steps != '0) ? RUN : IDLE;
            end
        end else if (bus.abort) begin
            w_next = IDLE;
        end else if (!bus.freeze && w_zero) begin
            w_step = 1'b1;
            w_next = w_last ? IDLE : RUN;
        end
    end

    // Phase is deliberately left alone on start so consecutive runs stay gray-continuous.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase  <= PHASE_INIT;
            r_rem    <= '0;
            r_period <= '0;
            r_dir    <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_done <= w_zero_start || (w_step && w_last);
            if (w_start) begin
                r_dir    <= bus.dir;
                r_period <= bus.period;
                r_rem    <= w_steps;
            end else if (w_step) begin
                r_phase <= next_phase(r_phase, r_dir);
                r_rem   <= r_rem - 1'b1;
            end
        end
    end

    assign bus.busy = r_state == RUN;
    assign bus.done = r_done;
    assign bus.remh = r_rem[15:8];
    assign bus.reml = r_rem[7:0];
`ifdef TACHGEN_INVPHASE_EN
    assign bus.tach = bus.invphase ? {r_phase[0], r_phase[1]} : r_phase;
`else
    assign bus.tach = r_phase;
`endif
endmodule

// File: tb/tb_tachgen16.sv
// tb_tachgen16: directed self-checking bench for tachgen16 with a quadrature decoder loopback model.
module tb_tachgen16;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int n_checks = 0;
    int n_fail = 0;
    logic [15:0] lb_cnt = '0;
    int lb_bad = 0;
    logic lb_clr = 1'b1;
    logic [1:0] lb_prev = 2'b00;
    logic [1:0] up_seq [4] = '{2'b01, 2'b11, 2'b10, 2'b00};
    logic [1:0] dn_seq [5] = '{2'b10, 2'b11, 2'b01, 2'b00, 2'b10};

    tachgen16_if bus ();
    tachgen16 dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic logic [1:0] gidx(input logic [1:0] p);
        return {p[1], p[1] ^ p[0]};
    endfunction

    // Independent receiver: +1 per up transition, -1 per down, illegal jumps tallied.
    always @(negedge clk) begin
        if (lb_clr) begin
            lb_cnt <= '0;
            lb_bad <= 0;
        end else begin
            case (2'(gidx(bus.tach) - gidx(lb_prev)))
                2'd1: lb_cnt <= lb_cnt + 16'd1;
                2'd3: lb_cnt <= lb_cnt - 16'd1;
                2'd2: lb_bad <= lb_bad + 1;
                default: ;
            endcase
        end
        lb_prev <= bus.tach;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go(input logic d, input logic [15:0] s, input logic [7:0] p);
        bus.dir    = d;
        bus.stepsh = s[15:8];
        bus.stepsl = s[7:0];
        bus.period = p;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!bus.done && n < budget) begin
            tick();
            n++;
        end
        check("done_timeout", 32'(bus.done), 1);
    endtask

    initial begin
        bus.start = 0; bus.abort = 0; bus.freeze = 0; bus.dir = 0;
        bus.stepsh = 0; bus.stepsl = 0; bus.period = 0;
`ifdef TACHGEN_INVPHASE_EN
        bus.invphase = 0;
`endif
        repeat (2) tick();
        check("rst_tach", 32'(bus.tach), 0);
        check("rst_busy", 32'(bus.busy), 0);
        check("rst_done", 32'(bus.done), 0);
        check("rst_rem", 32'({bus.remh, bus.reml}), 0);
        rst_n = 1'b1;
        tick();

        go(1, 4, 2);
        check("t1_busy", 32'(bus.busy), 1);
        check("t1_rem0", 32'({bus.remh, bus.reml}), 4);
        for (int k = 0; k < 4; k++) begin
            tick();
            tick();
            check("t1_hold", 32'(bus.tach), k == 0 ? 0 : 32'(up_seq[k-1]));
            tick();
            check("t1_tach", 32'(bus.tach), 32'(up_seq[k]));
            check("t1_rem", 32'({bus.remh, bus.reml}), 32'(3 - k));
            check("t1_busy", 32'(bus.busy), k < 3 ? 1 : 0);
            check("t1_done", 32'(bus.done), k == 3 ? 1 : 0);
        end
        tick();
        check("t1_done_off", 32'(bus.done), 0);

        go(0, 5, 0);
        check("t2_rem0", 32'({bus.remh, bus.reml}), 5);
        check("t2_tach0", 32'(bus.tach), 0);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("t2_tach", 32'(bus.tach), 32'(dn_seq[k]));
            check("t2_rem", 32'({bus.remh, bus.reml}), 32'(4 - k));
            check("t2_done", 32'(bus.done), k == 4 ? 1 : 0);
        end

        go(0, 0, 3);
        check("z_done", 32'(bus.done), 1);
        check("z_busy", 32'(bus.busy), 0);
        check("z_tach", 32'(bus.tach), 2);
        tick();
        check("z_done_off", 32'(bus.done), 0);

        bus.abort = 1'b1;
        go(1, 5, 0);
        bus.abort = 1'b0;
        check("sa_busy", 32'(bus.busy), 0);
        check("sa_done", 32'(bus.done), 0);
        tick();
        check("sa_tach", 32'(bus.tach), 2);

        go(1, 10, 1);
        check("t5_busy", 32'(bus.busy), 1);
        tick(); tick();
        check("t5_tr1", 32'(bus.tach), 0);
        tick(); tick();
        check("t5_tr2", 32'(bus.tach), 1);
        check("t5_rem2", 32'({bus.remh, bus.reml}), 8);
        bus.freeze = 1'b1;
        repeat (3) tick();
        check("t5_frz", 32'(bus.tach), 1);
        bus.freeze = 1'b0;
        bus.stepsl = 8'd2;
        bus.start  = 1'b1;
        tick();
        bus.start  = 1'b0;
        check("t5_stretch", 32'(bus.tach), 1);
        tick();
        check("t5_tr3", 32'(bus.tach), 3);
        check("t5_rem3", 32'({bus.remh, bus.reml}), 7);
        tick(); tick();
        check("t5_tr4", 32'(bus.tach), 2);
        tick(); tick();
        check("t5_tr5", 32'(bus.tach), 0);
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        check("ab_busy", 32'(bus.busy), 0);
        check("ab_done", 32'(bus.done), 0);
        check("ab_rem", 32'({bus.remh, bus.reml}), 5);
        check("ab_tach", 32'(bus.tach), 0);
        tick();
        check("ab_done2", 32'(bus.done), 0);

        lb_clr = 1'b1;
        tick();
        lb_clr = 1'b0;
        go(1, 1000, 7);
        wait_done(9000);
        go(0, 300, 7);
        wait_done(3000);
        tick();
        check("lb_count", 32'(lb_cnt), 'h2BC);
        check("lb_illegal", 32'(lb_bad), 0);
        check("lb_rem", 32'({bus.remh, bus.reml}), 0);

`ifdef TACHGEN_INVPHASE_EN
        bus.invphase = 1'b1;
        lb_clr = 1'b1;
        tick();
        lb_clr = 1'b0;
        go(1, 4, 0);
        tick();
        check("inv_tach", 32'(bus.tach), 2);
        wait_done(10);
        tick();
        check("inv_count", 32'(lb_cnt), 'hFFFC);
        bus.invphase = 1'b0;
`endif

        go(1, 100, 0);
        repeat (3) tick();
        check("mr_pre", 32'(bus.tach), 2);
        rst_n = 1'b0;
        #1;
        check("mr_busy", 32'(bus.busy), 0);
        check("mr_tach", 32'(bus.tach), 0);
        check("mr_rem", 32'({bus.remh, bus.reml}), 0);
        check("mr_done", 32'(bus.done), 0);
        tick();
        rst_n = 1'b1;
        tick();
        check("mr_idle", 32'(bus.busy), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
